// File: rtl/bus_rr_scheduler.sv
// bus_rr_scheduler
// Round-robin scheduler for the shared data bus. It picks one source FIFO
// with pending data, pops one packet, decodes the destination ID from the
// header and pushes the packet to one destination FIFO or to all of them
// except the source (broadcast). Pushes wait on destination back-pressure.
//
// Optional feature: define BUS_SCHED_STATS_EN to add per-source transfer
// counters (tx_count) and a dropped-packet counter (drop_count).

module bus_rr_scheduler #(
    parameter int width = 16,
    parameter int drivers = 4,
    parameter int id_bits = 8,
    parameter logic [id_bits-1:0] broadcast = {id_bits{1'b1}},
    localparam int gw = (drivers > 1) ? $clog2(drivers) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [drivers-1:0]        pndng,
    input  logic [drivers*width-1:0]  D_pop,
    input  logic [drivers-1:0]        full,
    output logic [drivers-1:0]        pop,
    output logic [drivers-1:0]        push,
    output logic [width-1:0]          D_push,
    output logic [gw-1:0]             grant_id,
    output logic                      busy,
    output logic                      err_addr
`ifdef BUS_SCHED_STATS_EN
    ,
    output logic [drivers*16-1:0]     tx_count,
    output logic [15:0]               drop_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ROUTE = 2'd2,
        PUSH  = 2'd3
    } sched_state_t;

    sched_state_t state_q;
    sched_state_t state_n;

    // Arbitration pointer and captured transfer context
    logic [gw-1:0]      last_q;
    logic [width-1:0]   pkt_q;
    logic [drivers-1:0] mask_q;

    // Round-robin search results
    logic               pick_valid;
    logic [gw-1:0]      pick_idx;
    logic [gw-1:0]      cand;

    // Header decode results
    logic [id_bits-1:0] dest;
    logic               dest_bcast;
    logic               dest_in_range;
    logic               dest_self;
    logic               route_ok;
    logic [drivers-1:0] route_mask;

    // Next values of the registered outputs
    logic [drivers-1:0] pop_n;
    logic [drivers-1:0] push_n;
    logic [width-1:0]   d_push_n;
    logic               err_n;

    // Search upward from the last granted source, wrapping, for the first pending FIFO
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= drivers; k++) begin
            cand = gw'((int'(last_q) + k) % drivers);
            if (!pick_valid && pndng[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Decode the destination field of the captured packet into a push mask
    always_comb begin
        dest          = pkt_q[width-1 -: id_bits];
        dest_bcast    = (dest == broadcast);
        dest_in_range = (int'(dest) < drivers);
        dest_self     = (dest == id_bits'(grant_id));
        route_ok      = dest_bcast || (dest_in_range && !dest_self);
        route_mask    = '0;
        if (dest_bcast) begin
            route_mask = ~(drivers'(1) << grant_id);
        end else if (dest_in_range) begin
            route_mask = drivers'(1) << dest;
        end
    end

    // State register; reset abandons any transfer in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic: one pass of IDLE -> POP -> ROUTE -> PUSH per packet
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_n = POP;
                end
            end
            POP: begin
                state_n = ROUTE;
            end
            ROUTE: begin
                state_n = route_ok ? PUSH : IDLE;
            end
            PUSH: begin
                if (push != '0) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output logic: compute the strobes that will be registered at this edge
    always_comb begin
        pop_n    = '0;
        push_n   = '0;
        d_push_n = D_push;
        err_n    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    pop_n = drivers'(1) << pick_idx;
                end
            end
            ROUTE: begin
                if (!route_ok) begin
                    err_n = 1'b1;
                end else if ((route_mask & full) == '0) begin
                    push_n   = route_mask;
                    d_push_n = pkt_q;
                end
            end
            PUSH: begin
                if ((push == '0) && ((mask_q & full) == '0)) begin
                    push_n   = mask_q;
                    d_push_n = pkt_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers so every strobe is glitch-free and one cycle wide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            err_addr <= 1'b0;
            busy     <= 1'b0;
        end else begin
            pop      <= pop_n;
            push     <= push_n;
            D_push   <= d_push_n;
            err_addr <= err_n;
            busy     <= (state_n != IDLE);
        end
    end

    // Grant pointer and packet capture; last starts at the top so driver 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id <= '0;
            last_q   <= gw'(drivers - 1);
            pkt_q    <= '0;
            mask_q   <= '0;
        end else begin
            if (state_q == IDLE && pick_valid) begin
                grant_id <= pick_idx;
                last_q   <= pick_idx;
            end
            if (state_q == POP) begin
                pkt_q <= D_pop[grant_id*width +: width];
            end
            if (state_q == ROUTE) begin
                mask_q <= route_mask;
            end
        end
    end

`ifdef BUS_SCHED_STATS_EN
    // Transfer statistics: a broadcast counts once against its source, counters wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (push_n != '0) begin
                tx_count[grant_id*16 +: 16] <= tx_count[grant_id*16 +: 16] + 16'd1;
            end
            if (err_n) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// tb_bus_rr_scheduler
// Self-checking bench for bus_rr_scheduler: a table of single transfers with
// cycle-exact checks, hand-written back-pressure / reset / round-robin
// sequences, and a randomized run against a transaction-level model.
// Optional feature macro: BUS_SCHED_STATS_EN.

module tb_bus_rr_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] D_pop;
    logic [3:0]  full;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] D_push;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err_addr;
`ifdef BUS_SCHED_STATS_EN
    logic [63:0] tx_count;
    logic [15:0] drop_count;
`endif

    int total = 0;
    int bad   = 0;

    bus_rr_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .full     (full),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy),
        .err_addr (err_addr)
`ifdef BUS_SCHED_STATS_EN
        ,
        .tx_count   (tx_count),
        .drop_count (drop_count)
`endif
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a hung design still ends the run
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        int          src;
        logic [15:0] pkt;
        logic [3:0]  full;
        logic        expErr;
        logic [3:0]  expMask;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] p, input int src, input logic [15:0] pkt, input logic [3:0] f);
        pndng = p;
        D_pop = 64'h0;
        D_pop[src*16 +: 16] = pkt;
        full = f;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        pndng = 4'h0;
        full  = 4'h0;
        D_pop = 64'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One packet from a single pending source, checked cycle by cycle
    task automatic runVector(input vec_t v);
        @(negedge clk);
        applyStimulus(4'b0001 << v.src, v.src, v.pkt, v.full);
        @(negedge clk);
        checkOutput("vec pop", pop, 4'b0001 << v.src);
        checkOutput("vec grant_id", grant_id, v.src);
        checkOutput("vec busy pop", busy, 1'b1);
        checkOutput("vec push early", push, 4'h0);
        pndng = 4'h0;
        @(negedge clk);
        checkOutput("vec pop route", pop, 4'h0);
        checkOutput("vec push route", push, 4'h0);
        checkOutput("vec err route", err_addr, 1'b0);
        @(negedge clk);
        if (v.expErr) begin
            checkOutput("vec err pulse", err_addr, 1'b1);
            checkOutput("vec push on err", push, 4'h0);
            checkOutput("vec busy err", busy, 1'b0);
        end else begin
            checkOutput("vec push", push, v.expMask);
            checkOutput("vec D_push", D_push, v.pkt);
            checkOutput("vec err none", err_addr, 1'b0);
        end
        @(negedge clk);
        checkOutput("vec push after", push, 4'h0);
        checkOutput("vec err after", err_addr, 1'b0);
        checkOutput("vec busy after", busy, 1'b0);
    endtask

    // Broadcast held off by full[3] for five sampled edges, then one strobe
    task automatic runBroadcastStall();
        @(negedge clk);
        applyStimulus(4'b0010, 1, 16'hFF55, 4'b1000);
        @(negedge clk);
        checkOutput("bc pop", pop, 4'b0010);
        pndng = 4'h0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bc stall push", push, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bc stall push", push, 4'h0);
            checkOutput("bc stall busy", busy, 1'b1);
        end
        full = 4'b0000;
        @(negedge clk);
        checkOutput("bc push", push, 4'b1101);
        checkOutput("bc D_push", D_push, 16'hFF55);
        @(negedge clk);
        checkOutput("bc push once", push, 4'h0);
        checkOutput("bc idle", busy, 1'b0);
    endtask

    // Reset while stalled in PUSH, then round-robin order restarts at driver 0
    task automatic runResetAndRoundRobin();
        int seen;
        doReset();
        @(negedge clk);
        applyStimulus(4'b0001, 0, 16'h0100, 4'b0010);
        @(negedge clk);
        checkOutput("rst pre pop", pop, 4'b0001);
        pndng = 4'h0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst stalled push", push, 4'h0);
        checkOutput("rst stalled busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("rst pop", pop, 4'h0);
        checkOutput("rst push", push, 4'h0);
        checkOutput("rst busy", busy, 1'b0);
        checkOutput("rst grant_id", grant_id, 2'd0);
        for (int i = 0; i < 4; i++) begin
            D_pop[i*16 +: 16] = {8'((i + 1) % 4), 8'(8'hA0 + i)};
        end
        pndng = 4'b1111;
        full  = 4'b0000;
        @(negedge clk);
        checkOutput("rst no pop", pop, 4'h0);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            seen = 0;
            for (int c = 0; c < 12 && seen == 0; c++) begin
                @(negedge clk);
                if (pop != 4'h0) seen = 1;
            end
            checkOutput("rr pop seen", seen, 1);
            checkOutput("rr pop order", pop, 4'b0001 << (j % 4));
        end
        pndng = 4'h0;
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        checkOutput("rr drained", busy, 1'b0);
    endtask

    // Randomized traffic checked against a queue-level round-robin model
    task automatic runRandom();
        logic [15:0] mem[4][16];
        int cnt[4];
        int hd[4];
        int mh[4];
        int expSrc[64];
        logic expErr[64];
        logic [3:0] expMask[64];
        logic [15:0] expData[64];
        int nPkts, lastM, c, popIdx, evIdx, removeSrc, cyc, r;
        logic [7:0] dst;
        logic [15:0] p;

        nPkts = 0;
        for (int d = 0; d < 4; d++) begin
            cnt[d] = $urandom_range(0, 10);
            if (d == 0 && cnt[d] == 0) cnt[d] = 1;
            hd[d] = 0;
            mh[d] = 0;
            nPkts += cnt[d];
            for (int k = 0; k < cnt[d]; k++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      dst = 8'($urandom_range(0, 3));
                else if (r < 8) dst = 8'hFF;
                else            dst = 8'($urandom_range(4, 254));
                mem[d][k] = {dst, 8'($urandom)};
            end
        end

        lastM = 3;
        for (int t = 0; t < nPkts; t++) begin
            c = lastM;
            for (int k = 1; k <= 4; k++) begin
                c = (lastM + k) % 4;
                if (mh[c] < cnt[c]) break;
            end
            lastM = c;
            p = mem[c][mh[c]];
            mh[c]++;
            expSrc[t]  = c;
            expData[t] = p;
            if (p[15:8] == 8'hFF) begin
                expErr[t]  = 1'b0;
                expMask[t] = 4'hF & ~(4'b0001 << c);
            end else if (p[15:8] < 4 && int'(p[15:8]) != c) begin
                expErr[t]  = 1'b0;
                expMask[t] = 4'b0001 << p[15:8];
            end else begin
                expErr[t]  = 1'b1;
                expMask[t] = 4'h0;
            end
        end

        popIdx = 0;
        evIdx = 0;
        removeSrc = -1;
        cyc = 0;
        for (int d = 0; d < 4; d++) begin
            pndng[d] = (hd[d] < cnt[d]);
            D_pop[d*16 +: 16] = (hd[d] < cnt[d]) ? mem[d][hd[d]] : 16'h0;
        end
        full = 4'h0;
        while (evIdx < nPkts && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (removeSrc >= 0) begin
                hd[removeSrc]++;
                removeSrc = -1;
            end
            if (pop != 4'h0) begin
                if (popIdx < nPkts) begin
                    checkOutput("rnd pop", pop, 4'b0001 << expSrc[popIdx]);
                    removeSrc = expSrc[popIdx];
                end else begin
                    checkOutput("rnd extra pop", pop, 4'h0);
                end
                popIdx++;
            end
            if (push != 4'h0 || err_addr) begin
                if (evIdx < nPkts) begin
                    checkOutput("rnd err", err_addr, expErr[evIdx]);
                    checkOutput("rnd push", push, expMask[evIdx]);
                    if (!expErr[evIdx]) checkOutput("rnd D_push", D_push, expData[evIdx]);
                end
                evIdx++;
            end
            for (int d = 0; d < 4; d++) begin
                pndng[d] = (hd[d] < cnt[d]);
                D_pop[d*16 +: 16] = (hd[d] < cnt[d]) ? mem[d][hd[d]] : 16'h0;
            end
            full = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        end
        full = 4'h0;
        checkOutput("rnd all delivered", evIdx, nPkts);
        checkOutput("rnd pop count", popIdx, nPkts);
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
        checkOutput("rnd idle at end", busy, 1'b0);
    endtask

    initial begin
`ifdef BUS_SCHED_STATS_EN
        int expTx[4];
        int expDrop;
`endif
        vecs[0] = '{src: 0, pkt: 16'h02AB, full: 4'b0000, expErr: 1'b0, expMask: 4'b0100};
        vecs[1] = '{src: 1, pkt: 16'hFF55, full: 4'b0000, expErr: 1'b0, expMask: 4'b1101};
        vecs[2] = '{src: 2, pkt: 16'h0711, full: 4'b0000, expErr: 1'b1, expMask: 4'b0000};
        vecs[3] = '{src: 2, pkt: 16'h0211, full: 4'b0000, expErr: 1'b1, expMask: 4'b0000};
        vecs[4] = '{src: 3, pkt: 16'h0012, full: 4'b1000, expErr: 1'b0, expMask: 4'b0001};
        vecs[5] = '{src: 0, pkt: 16'h0000, full: 4'b0000, expErr: 1'b1, expMask: 4'b0000};
        vecs[6] = '{src: 3, pkt: 16'hFF9C, full: 4'b0000, expErr: 1'b0, expMask: 4'b0111};
        vecs[7] = '{src: 0, pkt: 16'h0400, full: 4'b0000, expErr: 1'b1, expMask: 4'b0000};
        vecs[8] = '{src: 1, pkt: 16'h0301, full: 4'b0101, expErr: 1'b0, expMask: 4'b1000};

        reset = 1'b1;
        pndng = 4'h0;
        full  = 4'h0;
        D_pop = 64'h0;
        @(negedge clk);
        checkOutput("reset pop", pop, 4'h0);
        checkOutput("reset push", push, 4'h0);
        checkOutput("reset D_push", D_push, 16'h0);
        checkOutput("reset err_addr", err_addr, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset grant_id", grant_id, 2'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] single-transfer vectors");
        for (int i = 0; i < 9; i++) begin
            runVector(vecs[i]);
        end
`ifdef BUS_SCHED_STATS_EN
        expDrop = 0;
        for (int d = 0; d < 4; d++) expTx[d] = 0;
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].expErr) expDrop++;
            else expTx[vecs[i].src]++;
        end
        checkOutput("stats drop_count", drop_count, expDrop);
        for (int d = 0; d < 4; d++) checkOutput("stats tx_count", tx_count[d*16 +: 16], expTx[d]);
`endif

        $display("[TB] broadcast with back-pressure");
        runBroadcastStall();

        $display("[TB] reset while stalled, then round-robin");
        runResetAndRoundRobin();

`ifdef BUS_SCHED_STATS_EN
        $display("[TB] statistics from driver 3");
        doReset();
        for (int i = 0; i < 3; i++) begin
            runVector('{src: 3, pkt: 16'h0011, full: 4'b0000, expErr: 1'b0, expMask: 4'b0001});
        end
        for (int d = 0; d < 4; d++) checkOutput("stats d3 tx_count", tx_count[d*16 +: 16], (d == 3) ? 3 : 0);
        checkOutput("stats d3 drop_count", drop_count, 0);
`endif

        $display("[TB] randomized traffic");
        for (int run = 0; run < 4; run++) begin
            doReset();
            runRandom();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_rr_scheduler.md
# bus_rr_scheduler

Round-robin scheduler that sequences the shared data bus between the per-driver FIFOs in the bus verification environment. It selects one source FIFO with pending data, pops one packet, decodes the destination ID from the packet header and pushes the packet to one destination FIFO or to all of them (broadcast). Pushes wait on destination back-pressure. It sits between the FIFOs interface (pndng/pop/D_pop on the source side, push/D_push on the destination side) and the driver/monitor agents.

## Interface
- width, 16: packet size in bits.
- drivers, 4: number of source/destination FIFOs; must be ≥ 2.
- id_bits, 8: header field size; destination ID = pkt[width-1 -: id_bits].
- broadcast, {8{1'b1}}: ID value that means deliver to every driver except the source.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- pndng  in  drivers  source FIFO i holds at least one packet. The FIFO is first-word fall-through.
- D_pop  in  drivers*width  head packet of each source FIFO; slice i = D_pop[i*width +: width].
- full  in  drivers  destination FIFO i cannot accept a push.
- pop  out  drivers  one-hot, one-cycle pop strobe to the granted source.
- push  out  drivers  one-cycle push strobe mask to the destinations.
- D_push  out  width  packet being delivered; valid whenever push≠0.
- grant_id  out  $clog2(drivers)  index of the current or last granted source.
- busy  out  1  high in every state except IDLE.
- err_addr  out  1  one-cycle pulse when a packet is dropped because of an illegal destination.

## Operation
- FSM states: IDLE, POP, ROUTE, PUSH. All outputs come from registers.
- IDLE
  - If pndng≠0, choose the first set bit searching upward from last+1 modulo drivers.
  - Register the choice in grant_id and last, then go to POP.
  - If pndng=0, stay in IDLE.
- POP
  - Assert pop[grant_id] for exactly one cycle.
  - Capture D_pop slice grant_id into pkt.
  - Go to ROUTE.
- ROUTE: decode dest = pkt[width-1 -: id_bits].
  - dest==broadcast: mask = all ones with bit grant_id cleared.
  - dest<drivers and dest≠grant_id: mask = one-hot(dest).
  - Anything else (out of range, or self-addressed): pulse err_addr, drop pkt, return to IDLE.
  - On a legal destination, go to PUSH.
- PUSH
  - Wait while (mask & full)≠0; there is no timeout.
  - When (mask & full)=0: assert push=mask and D_push=pkt for one cycle, then go to IDLE.
  - Broadcast is all-or-nothing: no partial pushes.
- pndng changes outside IDLE have no effect until the next arbitration.
- Reset values:
  - state=IDLE; pop=0; push=0; D_push=0; err_addr=0; busy=0; grant_id=0.
  - last=drivers-1, so driver 0 wins first.
- Reset asserted mid-transfer: a popped packet that has not yet been pushed is lost; no pop or push strobe is issued after reset rises.

## Timing
- pndng sampled high in IDLE at edge n → pop high during cycle n+1 → ROUTE in cycle n+2 → earliest push during cycle n+3.
- Peak throughput: one packet every 4 cycles.
- Each back-pressure cycle in PUSH adds 1 cycle.
- err_addr is high for one cycle, during the cycle after ROUTE. The next arbitration happens in that same cycle, back in IDLE.
- Fairness: a continuously pending driver is granted at least once every drivers transfers.

## Configuration
- Macro BUS_SCHED_STATS_EN.
- When defined:
  - Adds output tx_count (drivers*16): per-source count of successfully pushed packets. Slice i = tx_count[i*16 +: 16].
  - Adds output drop_count (16): count of packets dropped on illegal destination.
  - Both counters are cleared by reset and wrap at 16'hFFFF→0.
  - A broadcast counts once, against the source.
- When not defined: neither port nor any counter logic exists; all other behaviour is identical.

## Test plan
- Single transfer: driver 0 pending with pkt 16'h02AB, full=0 → pop=4'b0001 at n+1, push=4'b0100 with D_push=16'h02AB at n+3.
- Round-robin: pndng=4'b1111 held, all packets legal → grant order 0,1,2,3,0; no driver is granted twice in a row.
- Broadcast: driver 1 sends 16'hFF55 → push=4'b1101 with D_push=16'hFF55. With full[3]=1 for 5 cycles, push stays 0 until full[3] falls, then one 4'b1101 strobe.
- Illegal destinations: 16'h0711 from driver 2 → err_addr pulse, push stays 0. A self-addressed 16'h0211 from driver 2 does the same. With BUS_SCHED_STATS_EN, drop_count=2.
- Reset in PUSH while stalled on full → pop=0, push=0, busy=0 immediately. The next grant goes to driver 0.
- Stats: 3 transfers from driver 3 → tx_count[3*16 +: 16]=3, other slices 0.
